// File: rtl/int_controller.sv
// Priority interrupt controller: edge-latched pending requests, per-source mask,
// lowest-index-wins arbitration and a REQ / SERVICE acknowledge handshake to one CPU.
module int_controller #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             global_int_en,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] int_mask,
  output logic [N_SRC-1:0] int_pending,
  output logic             cpu_irq,
  output logic [VEC_W-1:0] int_vec,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             in_service
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] hist_q, hist_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             cpu_irq_q, cpu_irq_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             in_service_q, in_service_d;

  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] eligible;
  logic [VEC_W-1:0] winner;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    edges    = irq_src & ~hist_q;
    eligible = pending_q & ~mask_q;

    // Scan from the top down so the lowest eligible index is the last to write.
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = VEC_W'(i);
    end

    state_d      = state_q;
    hist_d       = irq_src;
    pending_d    = pending_q;
    mask_d       = mask_we ? mask_wdata : mask_q;
    cpu_irq_d    = cpu_irq_q;
    vec_d        = vec_q;
    in_service_d = in_service_q;

    case (state_q)
      ST_IDLE: begin
        if (global_int_en && (eligible != '0)) begin
          state_d   = ST_REQ;
          vec_d     = winner;
          cpu_irq_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_d          = ST_SERVICE;
          cpu_irq_d        = 1'b0;
          in_service_d     = 1'b1;
          pending_d[vec_q] = 1'b0;
        end else if (!global_int_en) begin
          state_d   = ST_IDLE;
          cpu_irq_d = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cpu_irq_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase

    // Applied after the ack clear so a fresh edge on the acknowledged source wins.
    pending_d = pending_d | edges;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      hist_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      cpu_irq_q    <= 1'b0;
      vec_q        <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      cpu_irq_q    <= cpu_irq_d;
      vec_q        <= vec_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_mask    = mask_q;
  assign int_pending = pending_q;
  assign cpu_irq     = cpu_irq_q;
  assign int_vec     = vec_q;
  assign in_service  = in_service_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller: reset, single source, priority,
// mask, global disable and ack/edge collisions with hand-computed expectations.
module tb_int_controller;

  localparam int N_SRC = 4;
  localparam int VEC_W = 2;

  logic             clk;
  logic             clr_n;
  logic             global_int_en;
  logic [N_SRC-1:0] irq_src;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic [N_SRC-1:0] int_mask;
  logic [N_SRC-1:0] int_pending;
  logic             cpu_irq;
  logic [VEC_W-1:0] int_vec;
  logic             int_ack;
  logic             eoi;
  logic             in_service;

  int vectors;
  int miscompares;

  int_controller #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .global_int_en(global_int_en),
    .irq_src      (irq_src),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .int_mask     (int_mask),
    .int_pending  (int_pending),
    .cpu_irq      (cpu_irq),
    .int_vec      (int_vec),
    .int_ack      (int_ack),
    .eoi          (eoi),
    .in_service   (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    clr_n         = 1'b0;
    global_int_en = 1'b1;
    irq_src       = '0;
    mask_we       = 1'b0;
    mask_wdata    = '0;
    int_ack       = 1'b0;
    eoi           = 1'b0;

    tick();
    tick();
    check("rst_mask", 16'(int_mask), 16'h0);
    check("rst_pend", 16'(int_pending), 16'h0);
    check("rst_irq", 16'(cpu_irq), 16'h0);
    check("rst_vec", 16'(int_vec), 16'h0);
    check("rst_insvc", 16'(in_service), 16'h0);
    clr_n = 1'b1;

    // 1. Asynchronous reset while in REQ with pending 0101.
    irq_src = 4'b0101;
    tick();
    check("t1_pend", 16'(int_pending), 16'h5);
    check("t1_irq_lat", 16'(cpu_irq), 16'h0);
    irq_src = '0;
    tick();
    check("t1_irq", 16'(cpu_irq), 16'h1);
    check("t1_vec", 16'(int_vec), 16'h0);
    #2;
    clr_n = 1'b0;
    #1;
    check("t1_arst_pend", 16'(int_pending), 16'h0);
    check("t1_arst_irq", 16'(cpu_irq), 16'h0);
    check("t1_arst_insvc", 16'(in_service), 16'h0);
    check("t1_arst_mask", 16'(int_mask), 16'h0);
    tick();
    clr_n = 1'b1;
    tick();
    check("t1_post_irq", 16'(cpu_irq), 16'h0);

    // 2. Source 2 held high for 8 cycles gives exactly one request.
    irq_src = 4'b0100;
    tick();
    check("t2_pend", 16'(int_pending), 16'h4);
    check("t2_irq_lat", 16'(cpu_irq), 16'h0);
    tick();
    check("t2_irq", 16'(cpu_irq), 16'h1);
    check("t2_vec", 16'(int_vec), 16'h2);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("t2_ack_irq", 16'(cpu_irq), 16'h0);
    check("t2_ack_insvc", 16'(in_service), 16'h1);
    check("t2_ack_pend", 16'(int_pending), 16'h0);
    tick();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t2_eoi_insvc", 16'(in_service), 16'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) irq_src = '0;
      tick();
      check("t2_no_rereq", 16'(cpu_irq), 16'h0);
      check("t2_no_repend", 16'(int_pending), 16'h0);
    end

    // 3. Simultaneous edges on sources 3 and 1: 1 first, then 3.
    irq_src = 4'b1010;
    tick();
    irq_src = '0;
    check("t3_pend", 16'(int_pending), 16'ha);
    tick();
    check("t3_irq1", 16'(cpu_irq), 16'h1);
    check("t3_vec1", 16'(int_vec), 16'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("t3_pend_after1", 16'(int_pending), 16'h8);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t3_gap_irq", 16'(cpu_irq), 16'h0);
    tick();
    check("t3_irq2", 16'(cpu_irq), 16'h1);
    check("t3_vec2", 16'(int_vec), 16'h3);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("t3_pend_after2", 16'(int_pending), 16'h0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_third", 16'(cpu_irq), 16'h0);
    end

    // 4. Masked source 0 latches but waits for the mask to clear.
    mask_we    = 1'b1;
    mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    check("t4_mask", 16'(int_mask), 16'h1);
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    check("t4_pend", 16'(int_pending), 16'h1);
    tick();
    check("t4_masked_irq_a", 16'(cpu_irq), 16'h0);
    tick();
    check("t4_masked_irq_b", 16'(cpu_irq), 16'h0);
    mask_we    = 1'b1;
    mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    check("t4_unmask", 16'(int_mask), 16'h0);
    check("t4_unmask_irq_lat", 16'(cpu_irq), 16'h0);
    tick();
    check("t4_irq", 16'(cpu_irq), 16'h1);
    check("t4_vec", 16'(int_vec), 16'h0);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t4_done_pend", 16'(int_pending), 16'h0);

    // 5. Global disable in REQ drops the request, keeps pending; ack beats disable.
    irq_src = 4'b0100;
    tick();
    irq_src = '0;
    tick();
    check("t5_irq", 16'(cpu_irq), 16'h1);
    check("t5_vec", 16'(int_vec), 16'h2);
    global_int_en = 1'b0;
    tick();
    check("t5_dis_irq", 16'(cpu_irq), 16'h0);
    check("t5_dis_pend", 16'(int_pending), 16'h4);
    tick();
    check("t5_dis_hold", 16'(cpu_irq), 16'h0);
    global_int_en = 1'b1;
    tick();
    check("t5_reen_irq", 16'(cpu_irq), 16'h1);
    check("t5_reen_vec", 16'(int_vec), 16'h2);
    int_ack       = 1'b1;
    global_int_en = 1'b0;
    tick();
    int_ack       = 1'b0;
    global_int_en = 1'b1;
    check("t5_ackwin_insvc", 16'(in_service), 16'h1);
    check("t5_ackwin_pend", 16'(int_pending), 16'h0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;

    // 6. New source-1 edge in the ack cycle survives; ack/eoi ignored out of place.
    irq_src = 4'b0010;
    tick();
    irq_src = '0;
    tick();
    check("t6_irq", 16'(cpu_irq), 16'h1);
    check("t6_vec", 16'(int_vec), 16'h1);
    int_ack = 1'b1;
    irq_src = 4'b0010;
    tick();
    int_ack = 1'b0;
    irq_src = '0;
    check("t6_setwins_pend", 16'(int_pending), 16'h2);
    check("t6_setwins_insvc", 16'(in_service), 16'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("t6_svc_ack_pend", 16'(int_pending), 16'h2);
    check("t6_svc_ack_insvc", 16'(in_service), 16'h1);
    global_int_en = 1'b0;
    eoi           = 1'b1;
    tick();
    eoi = 1'b0;
    check("t6_eoi_insvc", 16'(in_service), 16'h0);
    int_ack = 1'b1;
    eoi     = 1'b1;
    tick();
    int_ack = 1'b0;
    eoi     = 1'b0;
    check("t6_idle_pend", 16'(int_pending), 16'h2);
    check("t6_idle_insvc", 16'(in_service), 16'h0);
    check("t6_idle_irq", 16'(cpu_irq), 16'h0);
    global_int_en = 1'b1;
    tick();
    check("t6_rereq_irq", 16'(cpu_irq), 16'h1);
    check("t6_rereq_vec", 16'(int_vec), 16'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("t6_final_pend", 16'(int_pending), 16'h0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t6_final_insvc", 16'(in_service), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
